// File: rtl/mreg_pkg.sv
// Shared definitions for the product register file and its sequencers.
package mreg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mreg_state_e;

    // Storage depth for an N-tap PE: one product register per tap after the first.
    function automatic int mreg_depth(input int n);
        return n - 1;
    endfunction

    // Wrap-around increment; depth need not be a power of two.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mul_reg.sv
// N-1 entry product register file: registered write, combinational read.
module mul_reg
    import mreg_pkg::*;
#(
    parameter int N           = 3,
    parameter int ADDRS_WIDTH = $clog2(N - 1),
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   mreg_rst_i,
    input  logic                   mreg_wr_en_i,
    input  logic [ADDRS_WIDTH-1:0] mreg_wr_addrs_i,
    input  logic [ADDRS_WIDTH-1:0] mreg_rd_addrs_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    output logic [DATA_WIDTH-1:0]  rd_data_o
);

    localparam int DEPTH = mreg_depth(N);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i or posedge mreg_rst_i) begin
        if (mreg_rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mreg_wr_en_i) begin
            mem[mreg_wr_addrs_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[mreg_rd_addrs_i];

endmodule

// File: rtl/mul_reg_ctrl.sv
// Circular-FIFO sequencer for mul_reg: write/read addressing, occupancy and
// start/last/done framing for the PE controller.
module mul_reg_ctrl
    import mreg_pkg::*;
#(
    parameter int N           = 3,
    parameter int ADDRS_WIDTH = $clog2(N - 1)
) (
    input  logic                   clk_i,
    input  logic                   mreg_rst_i,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    input  logic                   in_last_i,
    output logic                   in_ready_o,
    input  logic                   out_ready_i,
    output logic                   out_valid_o,
    output logic                   mreg_wr_en_o,
    output logic [ADDRS_WIDTH-1:0] mreg_wr_addrs_o,
    output logic [ADDRS_WIDTH-1:0] mreg_rd_addrs_o,
    output logic [$clog2(N)-1:0]   count_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [1:0]             state_o
);

    localparam int DEPTH = mreg_depth(N);
    localparam int CW    = $clog2(N);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]             state;
    logic [ADDRS_WIDTH-1:0] wr_ptr;
    logic [ADDRS_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic                   push;
    logic                   pop;

    // A transfer happens on a side only in a cycle where valid and ready are
    // both high at the clock edge; neither side may make valid depend on ready.
    // in_ready_o looks at out_ready_i so a full buffer can accept a word in the
    // same cycle it hands the oldest one out.
    assign full_o      = (count == DEPTH_C);
    assign empty_o     = (count == '0);
    assign in_ready_o  = (state == S_RUN) & (!full_o | out_ready_i);
    assign out_valid_o = !empty_o & ((state == S_RUN) | (state == S_DRAIN));
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign mreg_wr_en_o    = push;
    assign mreg_wr_addrs_o = wr_ptr;
    assign mreg_rd_addrs_o = rd_ptr;
    assign count_o         = count;
    assign busy_o          = (state != S_IDLE);
    assign done_o          = (state == S_DONE);
    assign state_o         = state;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge mreg_rst_i) begin
        if (mreg_rst_i) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ADDRS_WIDTH'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= ADDRS_WIDTH'(ptr_inc(int'(rd_ptr), DEPTH));
            end
            count <= count_next;

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state  <= S_RUN;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                    end
                end
                S_RUN: begin
                    if (push && in_last_i) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (count_next == '0) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_reg_ctrl.sv
// End-to-end bench: mul_reg_ctrl driving mul_reg at N=3 (instance a) and N=4 (instance b).
module tb_mul_reg_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance a: N=3, DEPTH=2
    logic        start_a = 0, in_valid_a = 0, in_last_a = 0, out_ready_a = 0;
    logic        in_ready_a, out_valid_a, wr_en_a, full_a, empty_a, busy_a, done_a;
    logic [0:0]  wr_addr_a, rd_addr_a;
    logic [1:0]  count_a, state_a;
    logic [15:0] wr_data_a = 0, rd_data_a;

    // Instance b: N=4, DEPTH=3
    logic        start_b = 0, in_valid_b = 0, in_last_b = 0, out_ready_b = 0;
    logic        in_ready_b, out_valid_b, wr_en_b, full_b, empty_b, busy_b, done_b;
    logic [1:0]  wr_addr_b, rd_addr_b;
    logic [1:0]  count_b, state_b;
    logic [15:0] wr_data_b = 0, rd_data_b;

    mul_reg_ctrl #(.N(3), .ADDRS_WIDTH(1)) u_ctrl_a (
        .clk_i(clk), .mreg_rst_i(rst), .start_i(start_a), .in_valid_i(in_valid_a),
        .in_last_i(in_last_a), .in_ready_o(in_ready_a), .out_ready_i(out_ready_a),
        .out_valid_o(out_valid_a), .mreg_wr_en_o(wr_en_a), .mreg_wr_addrs_o(wr_addr_a),
        .mreg_rd_addrs_o(rd_addr_a), .count_o(count_a), .full_o(full_a), .empty_o(empty_a),
        .busy_o(busy_a), .done_o(done_a), .state_o(state_a)
    );
    mul_reg #(.N(3), .ADDRS_WIDTH(1), .DATA_WIDTH(16)) u_reg_a (
        .clk_i(clk), .mreg_rst_i(rst), .mreg_wr_en_i(wr_en_a), .mreg_wr_addrs_i(wr_addr_a),
        .mreg_rd_addrs_i(rd_addr_a), .wr_data_i(wr_data_a), .rd_data_o(rd_data_a)
    );

    mul_reg_ctrl #(.N(4), .ADDRS_WIDTH(2)) u_ctrl_b (
        .clk_i(clk), .mreg_rst_i(rst), .start_i(start_b), .in_valid_i(in_valid_b),
        .in_last_i(in_last_b), .in_ready_o(in_ready_b), .out_ready_i(out_ready_b),
        .out_valid_o(out_valid_b), .mreg_wr_en_o(wr_en_b), .mreg_wr_addrs_o(wr_addr_b),
        .mreg_rd_addrs_o(rd_addr_b), .count_o(count_b), .full_o(full_b), .empty_o(empty_b),
        .busy_o(busy_b), .done_o(done_b), .state_o(state_b)
    );
    mul_reg #(.N(4), .ADDRS_WIDTH(2), .DATA_WIDTH(16)) u_reg_b (
        .clk_i(clk), .mreg_rst_i(rst), .mreg_wr_en_i(wr_en_b), .mreg_wr_addrs_i(wr_addr_b),
        .mreg_rd_addrs_i(rd_addr_b), .wr_data_i(wr_data_b), .rd_data_o(rd_data_b)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_qa[$];
    logic [15:0] exp_qb[$];
    logic [1:0]  exp_wr_b = 0;
    logic [1:0]  exp_rd_b = 0;
    int          pops_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on instance a: drive after the rising edge, return at the falling edge.
    task automatic cyc_a(input logic st, input logic v, input logic [15:0] d,
                         input logic last, input logic ordy);
        @(posedge clk);
        #1;
        start_a = st; in_valid_a = v; wr_data_a = d; in_last_a = last; out_ready_a = ordy;
        @(negedge clk);
        if (in_valid_a && in_ready_a) exp_qa.push_back(d);
    endtask

    // Scoreboard monitors: pop and compare whenever a consumer transfer happens.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (exp_qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected_pop: got 0x%0h expected none", rd_data_a);
            end else begin
                chk("a_pop_data", 32'(rd_data_a), 32'(exp_qa.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && wr_en_b) begin
            chk("b_wr_addr", 32'(wr_addr_b), 32'(exp_wr_b));
            exp_wr_b = (exp_wr_b == 2'd2) ? 2'd0 : exp_wr_b + 2'd1;
        end
        if (!rst && out_valid_b && out_ready_b) begin
            chk("b_rd_addr", 32'(rd_addr_b), 32'(exp_rd_b));
            exp_rd_b = (exp_rd_b == 2'd2) ? 2'd0 : exp_rd_b + 2'd1;
            pops_b++;
            if (exp_qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected_pop: got 0x%0h expected none", rd_data_b);
            end else begin
                chk("b_pop_data", 32'(rd_data_b), 32'(exp_qb.pop_front()));
            end
        end
    end

    initial begin
        int  nxt;
        bit  got_done;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count_a), 0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full", 32'(full_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_in_ready", 32'(in_ready_a), 0);
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_addrs", {wr_addr_a, rd_addr_a}, 0);
        chk("rst_b_empty", 32'(empty_b), 1);
        rst = 1'b0;

        // Fill N=3 to full, refuse a push without pop, then drain in order
        cyc_a(1, 0, 0, 0, 0);
        chk("a_start_idle", 32'(state_a), 32'(ST_IDLE));
        cyc_a(0, 1, 16'h0011, 0, 0);
        chk("a_run_ready", 32'(in_ready_a), 1);
        chk("a_wr_en", 32'(wr_en_a), 1);
        chk("a_wr_addr0", 32'(wr_addr_a), 0);
        cyc_a(0, 1, 16'h0022, 0, 0);
        chk("a_wr_addr1", 32'(wr_addr_a), 1);
        chk("a_count1", 32'(count_a), 1);
        chk("a_valid_after_push", 32'(out_valid_a), 1);
        cyc_a(0, 1, 16'h0099, 0, 0);
        chk("a_full", 32'(full_a), 1);
        chk("a_count2", 32'(count_a), 2);
        chk("a_full_not_ready", 32'(in_ready_a), 0);
        chk("a_full_no_write", 32'(wr_en_a), 0);
        chk("a_wr_wrap", 32'(wr_addr_a), 0);
        cyc_a(0, 0, 0, 0, 1);
        chk("a_full_ready_with_pop", 32'(in_ready_a), 1);
        cyc_a(0, 0, 0, 0, 1);
        chk("a_count_after_pop", 32'(count_a), 1);
        cyc_a(0, 0, 0, 0, 0);
        chk("a_empty", 32'(empty_a), 1);
        chk("a_empty_no_valid", 32'(out_valid_a), 0);

        // Full buffer: push 0x00AA in the same cycle as a pop
        cyc_a(0, 1, 16'h0033, 0, 0);
        cyc_a(0, 1, 16'h0044, 0, 0);
        cyc_a(0, 1, 16'h00AA, 0, 1);
        chk("a_sim_full", 32'(full_a), 1);
        chk("a_sim_wr_en", 32'(wr_en_a), 1);
        chk("a_sim_ptrs_equal", 32'(wr_addr_a), 32'(rd_addr_a));
        cyc_a(0, 0, 0, 0, 1);
        chk("a_sim_count_kept", 32'(count_a), 2);
        cyc_a(0, 0, 0, 0, 1);
        cyc_a(0, 0, 0, 0, 0);
        chk("a_sim_drained", 32'(exp_qa.size()), 0);

        // Last item into an empty buffer: DRAIN, one pop, DONE pulse
        cyc_a(0, 1, 16'h0005, 1, 0);
        cyc_a(0, 1, 16'h0077, 0, 0);
        chk("a_drain_state", 32'(state_a), 32'(ST_DRAIN));
        chk("a_drain_valid", 32'(out_valid_a), 1);
        chk("a_drain_data", 32'(rd_data_a), 32'h0005);
        chk("a_drain_not_ready", 32'(in_ready_a), 0);
        chk("a_drain_no_write", 32'(wr_en_a), 0);
        cyc_a(0, 0, 0, 0, 1);
        chk("a_no_early_done", 32'(done_a), 0);
        cyc_a(0, 0, 0, 0, 0);
        chk("a_done_pulse", 32'(done_a), 1);
        chk("a_done_no_valid", 32'(out_valid_a), 0);
        cyc_a(0, 0, 0, 0, 0);
        chk("a_done_one_cycle", 32'(done_a), 0);
        chk("a_idle_not_busy", 32'(busy_a), 0);

        // in_valid in IDLE ignored; start in RUN ignored
        cyc_a(0, 1, 16'h0066, 0, 0);
        chk("a_idle_no_write", 32'(wr_en_a), 0);
        chk("a_idle_not_ready", 32'(in_ready_a), 0);
        cyc_a(0, 0, 0, 0, 0);
        chk("a_idle_stays", 32'(state_a), 32'(ST_IDLE));
        chk("a_idle_count", 32'(count_a), 0);
        cyc_a(1, 0, 0, 0, 0);
        cyc_a(0, 1, 16'h0012, 0, 0);
        cyc_a(1, 1, 16'h0034, 0, 0);
        cyc_a(0, 0, 0, 0, 0);
        chk("a_start_in_run", 32'(state_a), 32'(ST_RUN));
        chk("a_start_in_run_count", 32'(count_a), 2);

        // Asynchronous reset mid-frame with two stored products
        #2;
        rst = 1'b1;
        #1;
        exp_qa.delete();
        chk("arst_count", 32'(count_a), 0);
        chk("arst_busy", 32'(busy_a), 0);
        chk("arst_in_ready", 32'(in_ready_a), 0);
        chk("arst_out_valid", 32'(out_valid_a), 0);
        chk("arst_empty", 32'(empty_a), 1);
        chk("arst_addrs", {wr_addr_a, rd_addr_a}, 0);
        chk("arst_rd_data", 32'(rd_data_a), 0);
        @(negedge clk);
        chk("arst_no_done", 32'(done_a), 0);
        #1;
        rst = 1'b0;
        cyc_a(0, 0, 0, 0, 0);
        chk("arst_idle_no_done", {30'd0, done_a, busy_a}, 0);

        // N=4: stream 1..7 with out_ready toggling 1,0,1,...
        @(posedge clk);
        #1;
        start_b = 1;
        nxt = 1;
        got_done = 0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            @(posedge clk);
            #1;
            start_b = 0;
            out_ready_b = (c % 2 == 0);
            in_valid_b = (nxt <= 7);
            wr_data_b = 16'(nxt);
            in_last_b = (nxt == 7);
            @(negedge clk);
            if (in_valid_b && in_ready_b) begin
                exp_qb.push_back(16'(nxt));
                nxt++;
            end
            if (done_b) got_done = 1;
        end
        chk("b_done_seen", 32'(got_done), 1);
        chk("b_all_pushed", 32'(nxt), 8);
        chk("b_pop_count", 32'(pops_b), 7);
        chk("b_queue_empty", 32'(exp_qb.size()), 0);
        @(posedge clk);
        #1;
        in_valid_b = 0; out_ready_b = 0;
        @(negedge clk);
        chk("b_idle_after", 32'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
